// File: rtl/rr_pop_arbiter.sv
// Round-robin pop arbiter over a bank of FIFOs with a one-entry registered output stage.
// Define ARB_PROPS_EN to add per-FIFO wait counters and fairness/protocol assertions.
module rr_pop_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_FIFOS-1:0]       empty,
    input  logic [NUM_FIFOS*WIDTH-1:0] flat_fifo_data_out,
    output logic [NUM_FIFOS-1:0]       gnt,
    output logic                       req,
    output logic [TAGWIDTH-1:0]        gnt_sel,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAGWIDTH-1:0]        out_tag,
    output logic                       out_vld,
    input  logic                       out_rdy
);

    localparam int                  TW1   = TAGWIDTH + 1;
    localparam logic [TAGWIDTH:0]   NUM_W = TW1'(NUM_FIFOS);
    localparam logic [TAGWIDTH-1:0] LAST  = TAGWIDTH'(NUM_FIFOS - 1);

    logic [TAGWIDTH-1:0] ptr;
    logic [TAGWIDTH-1:0] win;
    logic [TAGWIDTH-1:0] ptr_nxt;
    logic [TAGWIDTH:0]   idx;
    logic                found;
    logic                accept;
    logic                grant;
    logic [WIDTH-1:0]    head;

    // Scan ptr, ptr+1, ... with an explicit subtract-wrap so non-power-of-2 banks work.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            idx = {1'b0, ptr} + TW1'(k);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!found && !empty[idx[TAGWIDTH-1:0]]) begin
                found = 1'b1;
                win   = idx[TAGWIDTH-1:0];
            end
        end
    end

    assign accept  = !out_vld || out_rdy;
    assign grant   = rst && accept && found;
    assign req     = grant;
    assign gnt_sel = grant ? win : '0;
    assign head    = flat_fifo_data_out[win*WIDTH +: WIDTH];
    assign ptr_nxt = (win == LAST) ? '0 : win + TAGWIDTH'(1);

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (grant) begin
            ptr      <= ptr_nxt;
            out_vld  <= 1'b1;
            out_data <= head;
            out_tag  <= win;
        end else if (out_vld && out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

`ifdef ARB_PROPS_EN
    localparam logic [TAGWIDTH:0] CNT_MAX  = '1;
    localparam logic [TAGWIDTH:0] WAIT_LIM = TW1'(NUM_FIFOS - 1);

    logic [TAGWIDTH:0] wait_cnt [NUM_FIFOS];
    logic              prev_hold;
    logic [WIDTH-1:0]  prev_data;

    // A waiting FIFO only ages on cycles where a grant was actually possible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                wait_cnt[i] <= '0;
            end
            prev_hold <= 1'b0;
            prev_data <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (gnt[i] || empty[i]) begin
                    wait_cnt[i] <= '0;
                end else if (accept && wait_cnt[i] != CNT_MAX) begin
                    wait_cnt[i] <= wait_cnt[i] + TW1'(1);
                end
            end
            prev_hold <= out_vld && !out_rdy;
            prev_data <= out_data;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(gnt));
            assert ((gnt & empty) == '0);
            for (int i = 0; i < NUM_FIFOS; i++) begin
                assert (wait_cnt[i] <= WAIT_LIM);
            end
            if (prev_hold) begin
                assert (out_vld && out_data == prev_data);
            end
        end
    end
`endif

endmodule
